// File: rtl/apb_dual_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : apb_dual_master_arb
// Purpose  : Two-client APB master. Accepts valid/ready register requests from
//            two on-chip clients, grants one at a time round-robin, runs the
//            APB SETUP/ACCESS sequence (PREADY wait states honoured) and returns
//            the response to the client that won the grant.
// Ports    : PCLK, PRESETn (async, active-low)
//            m0_req_* / m1_req_*  : client request (valid, write, addr, wdata, ready)
//            m0_rsp_* / m1_rsp_*  : client response (valid, rdata, err)
//            PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY : APB master
// Options  : APB_TIMEOUT_EN - abort an ACCESS phase after TIMEOUT_CYC wait
//            cycles and report it on mX_rsp_err. Undefined: rsp_err tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module apb_dual_master_arb #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              m0_req_valid,
  input  logic              m0_req_write,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  output logic              m0_req_ready,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_rdata,
  output logic              m0_rsp_err,
  input  logic              m1_req_valid,
  input  logic              m1_req_write,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  output logic              m1_req_ready,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_rdata,
  output logic              m1_rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last_grant;   // 1: m1 was granted last, so m0 wins a tie
  logic   r_owner;        // client that owns the transfer in flight
  logic   w_gnt0;
  logic   w_gnt1;
  logic   w_done;         // ACCESS completes with PREADY this cycle
  logic   w_abort;        // ACCESS abandoned by the timeout this cycle

`ifdef APB_TIMEOUT_EN
  localparam int               CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] c_tmo_max = CNT_W'(TIMEOUT_CYC);
  logic [CNT_W-1:0] r_tmo_cnt;
`endif

  // APB strobes are pure decodes of the state register, so the async reset
  // removes them immediately.
  assign PSEL    = (r_state != S_IDLE);
  assign PENABLE = (r_state == S_ACCESS);

  assign m0_req_ready = w_gnt0;
  assign m1_req_ready = w_gnt1;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the client that was not granted last wins.
        if (m0_req_valid && (!m1_req_valid || r_last_grant)) begin
          w_gnt0 = 1'b1;
        end else if (m1_req_valid) begin
          w_gnt1 = 1'b1;
        end
        if (m0_req_valid || m1_req_valid) begin
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (r_tmo_cnt == c_tmo_max) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      m0_rsp_valid <= 1'b0;
      m1_rsp_valid <= 1'b0;
      m0_rsp_rdata <= '0;
      m1_rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      m0_rsp_err   <= 1'b0;
      m1_rsp_err   <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      m0_rsp_valid <= (w_done || w_abort) && !r_owner;
      m1_rsp_valid <= (w_done || w_abort) &&  r_owner;
`ifdef APB_TIMEOUT_EN
      m0_rsp_err   <= w_abort && !r_owner;
      m1_rsp_err   <= w_abort &&  r_owner;
`endif
      // Address/data phase registers only move on a grant; they keep the
      // last transfer's values while idle.
      if (w_gnt0 || w_gnt1) begin
        r_owner      <= w_gnt1;
        r_last_grant <= w_gnt1;
        PWRITE       <= w_gnt1 ? m1_req_write : m0_req_write;
        PADDR        <= w_gnt1 ? m1_req_addr  : m0_req_addr;
        PWDATA       <= w_gnt1 ? m1_req_wdata : m0_req_wdata;
      end
      // Read data is captured only for a successful read; writes and aborts
      // return 0. The value then holds until that client's next response.
      if (w_done || w_abort) begin
        if (!r_owner) begin
          m0_rsp_rdata <= (w_done && !PWRITE) ? PRDATA : '0;
        end else begin
          m1_rsp_rdata <= (w_done && !PWRITE) ? PRDATA : '0;
        end
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  // Counts ACCESS cycles spent waiting; restarted in SETUP and saturating at
  // the limit, where the ACCESS cycle decides between completion and abort.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !PREADY && (r_tmo_cnt != c_tmo_max)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign m0_rsp_err = 1'b0;
  assign m1_rsp_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/apb_dual_master_arb.md
Name: apb_dual_master_arb

Overview:
Two-requester APB master and arbiter that shares the single 4-register APB peripheral between two on-chip clients.
- Each client issues simple valid/ready register requests.
- The block grants one request at a time, round-robin.
- It sequences the APB SETUP/ACCESS phases, honours PREADY wait states and returns read data to the winning client.

Parameters:
ADDR_W, 8, width of PADDR and client address fields
DATA_W, 8, width of PWDATA/PRDATA and client data fields
TIMEOUT_CYC, 16, max ACCESS cycles with PREADY low before abort (used only with APB_TIMEOUT_EN)

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
m0_req_valid / m1_req_valid  in  1  client request pending
m0_req_write / m1_req_write  in  1  1=write, 0=read
m0_req_addr / m1_req_addr  in  ADDR_W  register address
m0_req_wdata / m1_req_wdata  in  DATA_W  write data
m0_req_ready / m1_req_ready  out  1  request accepted (1-cycle pulse)
m0_rsp_valid / m1_rsp_valid  out  1  transfer complete (1-cycle pulse)
m0_rsp_rdata / m1_rsp_rdata  out  DATA_W  read data; 0 for writes
m0_rsp_err / m1_rsp_err  out  1  transfer aborted by timeout
PSEL, PENABLE, PWRITE  out  1  APB control
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready

Behaviour:
- Clock is PCLK. Reset is PRESETn, asynchronous, active-low.
- Reset values: all outputs 0; FSM=IDLE; last_grant=1, so m0 wins the first contention.
- FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- IDLE, any req_valid=1:
  - Select winner. Only one valid -> that client. Both valid -> client != last_grant.
  - mX_req_ready is combinational, high in this IDLE cycle for the winner only.
  - Latch write/addr/wdata into PWRITE/PADDR/PWDATA.
  - Update last_grant; go SETUP.
- SETUP -> ACCESS unconditionally after 1 cycle.
- ACCESS, PREADY=0: hold all APB outputs stable (wait state).
- ACCESS, PREADY=1:
  - Next cycle: PSEL=PENABLE=0, FSM=IDLE.
  - Winner's rsp_valid pulses for 1 cycle.
  - rsp_rdata = PRDATA sampled at that edge for reads, 0 for writes.
  - rsp_rdata holds its value until the next response to that client.
- Latency: req accepted cycle N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid N+3 with zero wait states.
  - The next grant may occur in cycle N+3 (rsp_valid and IDLE grant coincide).
  - Peak throughput: 1 transfer / 3 cycles.
- Client rules:
  - Hold valid and fields stable until ready.
  - A new request may be raised in the same cycle as rsp_valid.
  - Dropping valid before ready is permitted; the request is simply not issued.
- Non-winning client's valid stays pending; it is guaranteed the next grant (no starvation).
- PADDR/PWDATA/PWRITE retain last value in IDLE; only PSEL/PENABLE are deasserted.
- Reset mid-transfer: PSEL/PENABLE drop immediately (async); no rsp_valid is issued; in-flight request is lost.
- rsp_err: never asserted unless the optional feature is enabled.

Optional Feature:
Macro APB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYC+1) counts ACCESS cycles with PREADY=0; it clears on entering SETUP.
  - When the count reaches TIMEOUT_CYC with PREADY still 0: drop PSEL/PENABLE, go IDLE.
  - Pulse winner's rsp_valid and rsp_err together; rsp_rdata=0.
  - PREADY=1 in the same cycle the count hits its limit: normal completion, err=0.
- Undefined: no counter logic; rsp_err ports tied 0; ACCESS waits indefinitely for PREADY.

Test Plan:
- m0 write addr 0x02 data 0xA5, PREADY=1; then m1 read addr 0x02 -> PSEL/PENABLE sequence 0/0,1/0,1/1; m1_rsp_valid with m1_rsp_rdata=0xA5 three cycles after m1_req_ready.
- Both clients valid every cycle, 4 reads each -> grants strictly m0,m1,m0,m1,...; first grant m0; no two consecutive grants to the same client.
- m0 read 0x01, PREADY low 3 ACCESS cycles -> APB outputs stable 4 ACCESS cycles; m0_rsp_valid at cycle N+6.
- Assert PRESETn=0 during ACCESS of m1 write -> PSEL=PENABLE=0 immediately, no m1_rsp_valid; after release m0 wins first contention.
- APB_TIMEOUT_EN, TIMEOUT_CYC=16, PREADY held 0 -> m0_rsp_valid and m0_rsp_err high after 16 wait cycles, rdata=0; next request completes normally with err=0.
- m0 valid raised then dropped while m1 transfer is in ACCESS -> m0 never granted; no APB transfer for m0.
